// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
interface sync_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  write_en;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;

  // Side that issues requests and consumes status/read data.
  modport master (
    output write_en,
    output read_en,
    output data_in,
    input  data_out,
    input  empty,
    input  full
  );

  // FIFO side.
  modport slave (
    input  write_en,
    input  read_en,
    input  data_in,
    output data_out,
    output empty,
    output full
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and pointer-decoded flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  sync_fifo_if.slave  bus
);

  localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic w_empty;
  logic w_full;
  logic w_rd_accept;
  logic w_wr_accept;

  // Status flags decoded straight from the registered pointers.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                   (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

  // A read frees a slot this cycle, so a write into a full FIFO may proceed alongside it.
  assign w_rd_accept = bus.read_en && !w_empty;
  assign w_wr_accept = bus.write_en && (!w_full || w_rd_accept);

  assign bus.data_out = r_data_out;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;

  // Storage array: written on accepted writes, never cleared.
  always_ff @(posedge clk) begin
    if (!rst_n && w_wr_accept) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
    end
  end

  // Pointer and read-data registers; reset takes priority over any request.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      end
      if (w_rd_accept) begin
        r_data_out <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        r_rd_ptr   <= r_rd_ptr + PTR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: constant vector table plus a queue scoreboard.
module tb_sync_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;

  logic clk;
  logic rst_n;

  sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

  sync_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic          rst;
    logic          we;
    logic          re;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dout;
    logic          exp_empty;
    logic          exp_full;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] sb_dout;
  int            n_checks;
  int            n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic we, input logic re,
                              input logic [DW-1:0] din, input logic [DW-1:0] dout,
                              input logic emp, input logic ful);
    vec_t v;
    v.rst = rst; v.we = we; v.re = re; v.din = din;
    v.exp_dout = dout; v.exp_empty = emp; v.exp_full = ful;
    vecs.push_back(v);
  endfunction

  // Drive one cycle, update the scoreboard, then compare DUT against it.
  task automatic step(input string tag, input logic rst, input logic we,
                      input logic re, input logic [DW-1:0] din);
    logic rd_ok;
    logic wr_ok;
    rst_n       = rst;
    bus.write_en = we;
    bus.read_en  = re;
    bus.data_in  = din;
    if (rst) begin
      sb_q.delete();
      sb_dout = '0;
    end else begin
      rd_ok = re && (sb_q.size() > 0);
      wr_ok = we && ((sb_q.size() < DEPTH) || rd_ok);
      if (rd_ok) sb_dout = sb_q.pop_front();
      if (wr_ok) sb_q.push_back(din);
    end
    @(posedge clk);
    #1;
    check({tag, " sb dout"},  32'(bus.data_out), 32'(sb_dout));
    check({tag, " sb empty"}, 32'(bus.empty),    32'(sb_q.size() == 0));
    check({tag, " sb full"},  32'(bus.full),     32'(sb_q.size() == DEPTH));
  endtask

  // Step plus comparison against hand-derived constants.
  task automatic step_exp(input string tag, input logic rst, input logic we,
                          input logic re, input logic [DW-1:0] din,
                          input logic [DW-1:0] dout, input logic emp, input logic ful);
    step(tag, rst, we, re, din);
    check({tag, " dout"},  32'(bus.data_out), 32'(dout));
    check({tag, " empty"}, 32'(bus.empty),    32'(emp));
    check({tag, " full"},  32'(bus.full),     32'(ful));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sb_dout  = '0;
    rst_n        = 1'b1;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    bus.data_in  = '0;

    // Reset with active requests, fill, overflow attempt.
    add(1, 1, 1, 8'h3C, 8'h00, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 8'(i), 8'h00, 0, i == 7);
    add(0, 1, 0, 8'hAA, 8'h00, 0, 1);
    // Drain, then underflow attempt.
    for (int i = 0; i < 8; i++) add(0, 0, 1, 8'h00, 8'(i), i == 7, 0);
    add(0, 0, 1, 8'h00, 8'h07, 1, 0);
    // Refill across the pointer wrap, partial drain, simultaneous op mid-occupancy.
    for (int i = 0; i < 8; i++) add(0, 1, 0, 8'(i), 8'h07, 0, i == 7);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 8'h00, 8'(i), 0, 0);
    add(0, 1, 1, 8'h55, 8'h04, 0, 0);
    add(0, 0, 1, 8'h00, 8'h05, 0, 0);
    add(0, 0, 1, 8'h00, 8'h06, 0, 0);
    add(0, 0, 1, 8'h00, 8'h07, 0, 0);
    add(0, 0, 1, 8'h00, 8'h55, 1, 0);
    // Simultaneous write/read while empty: only the write lands.
    add(0, 1, 1, 8'h11, 8'h55, 0, 0);
    add(0, 0, 1, 8'h00, 8'h11, 1, 0);

    foreach (vecs[i]) begin
      step_exp($sformatf("vec%0d", i), vecs[i].rst, vecs[i].we, vecs[i].re,
               vecs[i].din, vecs[i].exp_dout, vecs[i].exp_empty, vecs[i].exp_full);
    end

    // Simultaneous write/read while full: oldest out, full holds, new data last.
    for (int i = 0; i < 8; i++)
      step_exp($sformatf("fullfill%0d", i), 0, 1, 0, 8'(8'h20 + i), 8'h11, 0, i == 7);
    step_exp("full_wr_rd", 0, 1, 1, 8'h99, 8'h20, 0, 1);
    for (int i = 1; i < 8; i++)
      step_exp($sformatf("full_drain%0d", i), 0, 0, 1, 8'h00, 8'(8'h20 + i), 0, 0);
    step_exp("full_last", 0, 0, 1, 8'h00, 8'h99, 1, 0);

    // Reset mid-operation discards contents; later read is ignored.
    for (int i = 0; i < 5; i++)
      step_exp($sformatf("mid_fill%0d", i), 0, 1, 0, 8'(8'h40 + i), 8'h99, 0, 0);
    step_exp("mid_rst", 1, 1'($urandom), 1'($urandom), 8'($urandom), 8'h00, 1, 0);
    step_exp("post_rst_rd", 0, 0, 1, 8'h00, 8'h00, 1, 0);
    step_exp("post_rst_wr", 0, 1, 0, 8'h77, 8'h00, 0, 0);
    step_exp("post_rst_rd2", 0, 0, 1, 8'h00, 8'h77, 1, 0);

    // Random traffic checked by the scoreboard only.
    for (int i = 0; i < 300; i++)
      step($sformatf("rand%0d", i), 1'($urandom_range(0, 49) == 0),
           1'($urandom), 1'($urandom), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock synchronous FIFO buffering 8-bit data words between a producer and a consumer in the same clock domain.
- Default depth is 8 entries.
- Provides full/empty status flags and a registered read-data output.
- Sits between any two same-clock blocks that need rate decoupling.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out in bits.
- DEPTH, 8, number of storage entries; must be a power of two, at least 2.
- ADDR_WIDTH, 3, log2(DEPTH); pointers are ADDR_WIDTH+1 bits wide (extra wrap bit).

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- rst_n  input  1  synchronous reset, active-high: 1 sampled at posedge resets the block (name kept per codebase convention; polarity is high).
- write_en  input  1  write request; data_in is pushed at posedge if accepted.
- read_en  input  1  read request; oldest entry is popped to data_out at posedge if accepted.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- empty  output  1  high when FIFO holds 0 entries.
- full  output  1  high when FIFO holds DEPTH entries.

Behaviour:
- Reset (rst_n=1 at posedge) sets: wr_ptr=0, rd_ptr=0, data_out=0, empty=1, full=0.
  - Storage array is not cleared.
  - Reset has priority over any simultaneous read or write; reset mid-operation discards all contents.
- Pointers are (ADDR_WIDTH+1)-bit binary counters that wrap naturally modulo 2*DEPTH; the low ADDR_WIDTH bits index memory.
- empty = (wr_ptr == rd_ptr).
- full = (MSBs differ) and (low ADDR_WIDTH bits equal).
  - Both flags are combinational decodes of registered pointers, so they change in the same cycle as the pointer update (no extra latency).
- Write accepted when write_en=1 and (full=0 or read accepted this cycle).
  - On accept: mem[wr_ptr low bits] <= data_in; wr_ptr <= wr_ptr+1.
- Read accepted when read_en=1 and empty=0.
  - On accept: data_out <= mem[rd_ptr low bits]; rd_ptr <= rd_ptr+1.
  - Read latency: data visible on data_out after the same posedge that sampled read_en.
- data_out holds its last value when no read is accepted; no fall-through.
- Write while full (no read): ignored; contents, pointers and flags are unchanged.
- Read while empty: ignored; data_out holds and pointers are unchanged.
- Simultaneous write and read, FIFO neither empty nor full: both occur; occupancy is unchanged.
- Simultaneous write and read, empty: only the write occurs; data_out holds; empty deasserts next cycle.
- Simultaneous write and read, full: both occur; read returns the oldest entry; full stays 1.
- Wrap-around: after 2*DEPTH total operations the pointers roll over transparently; FIFO ordering is preserved across the wrap.
- Inputs are sampled only at posedge; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: rst_n=1 for one cycle with random inputs -> empty=1, full=0, data_out=0.
- Fill: write_en=1 with data_in 0..7 over 8 cycles.
  - empty drops after the 1st edge.
  - full=1 after the 8th edge.
  - A 9th write of 8'hAA is ignored; full stays 1.
- Drain: read_en=1 for 8 cycles -> data_out=0,1,...,7 on successive edges; empty=1 after the 8th.
  - A further read keeps data_out=7 and empty=1.
- Wrap-around: refill with 0..7, read 4 -> data_out 0..3.
  - Then assert write_en and read_en together with data_in=8'h55 -> data_out=4; occupancy stays 4.
  - Reading on -> 5,6,7,8'h55, then empty=1.
- Boundary simultaneous: when empty, write and read together with 8'h11 -> data_out unchanged, empty=0.
  - When full, write and read together -> oldest entry is output; full stays 1; the new data is read last.
- Reset mid-operation: fill 5 entries, assert rst_n=1 -> empty=1, full=0, data_out=0.
  - A subsequent read is ignored.
